// File: rtl/graph_pkg.sv
// Shared types for the graph-memory fetch path: FSM states, read-tracking slots
// and the {proc, index} address packing used on both memory ports.
package graph_pkg;

  localparam int DEFAULT_RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE, IDX_LO, IDX_HI, IDX_WAIT, STREAM, DRAIN, DONE
  } fetch_state_t;

  // One stage of a read-latency tracker: the read is live, plus a 1-bit tag
  // (HI row pointer on the index port, last beat on the edge port).
  typedef struct packed {
    logic vld;
    logic tag;
  } rd_slot_t;

  // Callers truncate to 32+PROC_BITS; proc arrives zero-extended.
  function automatic logic [63:0] pack_addr(input logic [31:0] proc, input logic [31:0] index);
    return {proc, index};
  endfunction

endpackage

// File: rtl/csr_neighbor_fetcher_fifo.sv
// Synchronous FIFO with a fall-through head. A push is accepted while full
// only if a pop happens in the same cycle.
module csr_neighbor_fetcher_fifo #(
  parameter int DATA_WIDTH = 33,
  parameter int DEPTH      = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          din,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/csr_neighbor_fetcher.sv
// Reads the CSR row pointers for one vertex, then issues credit-limited edge
// reads and streams the returned neighbour IDs out with valid/ready/last.
module csr_neighbor_fetcher
  import graph_pkg::*;
#(
  parameter int PROC_BITS  = 4,
  parameter int RD_LAT     = DEFAULT_RD_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_vertex,
  input  logic [PROC_BITS-1:0]    req_proc,
  output logic [32+PROC_BITS-1:0] idx_addr,
  output logic                    idx_validin,
  input  logic [31:0]             rowidx_out,
  output logic [32+PROC_BITS-1:0] data_addra,
  output logic                    data_validina,
  input  logic [31:0]             data_outa,
  output logic                    nbr_valid,
  input  logic                    nbr_ready,
  output logic [31:0]             nbr_data,
  output logic                    nbr_last,
  output logic [PROC_BITS-1:0]    nbr_proc,
  output logic                    done_out,
  output logic [31:0]             deg_out,
  output logic                    err_out
);

  localparam int AW  = 32 + PROC_BITS;
  localparam int FCW = $clog2(FIFO_DEPTH+1);
  localparam int CW  = FCW + 1;

  fetch_state_t           state_q, state_d;
  logic [31:0]            v_q, beg_q, ptr_q, rem_q, deg_q;
  logic [PROC_BITS-1:0]   proc_q;
  logic                   err_q;
  rd_slot_t [RD_LAT:1]    idx_pipe, dat_pipe;
  logic [CW-1:0]          inflight_q;
  logic [FCW-1:0]         fifo_cnt;
  logic [32:0]            fifo_dout;
  logic                   fifo_empty, pop, credit_ok, idx_ret_lo, idx_ret_hi;
  logic [31:0]            deg_w;
  logic                   err_w;

  assign idx_ret_lo = idx_pipe[RD_LAT].vld && !idx_pipe[RD_LAT].tag;
  assign idx_ret_hi = idx_pipe[RD_LAT].vld &&  idx_pipe[RD_LAT].tag;
  assign err_w      = rowidx_out < beg_q;
  assign deg_w      = err_w ? 32'd0 : rowidx_out - beg_q;
  // Everything issued but not yet popped must fit in the return buffer.
  assign credit_ok  = (inflight_q + CW'(fifo_cnt)) < CW'(FIFO_DEPTH);

  assign nbr_valid = !fifo_empty;
  assign pop       = nbr_valid && nbr_ready;
  assign nbr_data  = nbr_valid ? fifo_dout[31:0] : '0;
  assign nbr_last  = nbr_valid && fifo_dout[32];
  assign nbr_proc  = proc_q;

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    idx_validin   = 1'b0;
    idx_addr      = '0;
    data_validina = 1'b0;
    data_addra    = '0;
    done_out      = 1'b0;
    deg_out       = '0;
    err_out       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = IDX_LO;
      end
      IDX_LO: begin
        idx_validin = 1'b1;
        idx_addr    = AW'(pack_addr(32'(proc_q), v_q));
        state_d     = IDX_HI;
      end
      IDX_HI: begin
        idx_validin = 1'b1;
        idx_addr    = AW'(pack_addr(32'(proc_q), v_q + 32'd1));
        state_d     = IDX_WAIT;
      end
      IDX_WAIT: begin
        if (idx_ret_hi) state_d = (deg_w == 32'd0) ? DONE : STREAM;
      end
      STREAM: begin
        if (credit_ok) begin
          data_validina = 1'b1;
          data_addra    = AW'(pack_addr(32'(proc_q), ptr_q));
          if (rem_q == 32'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_dout[32]) state_d = DONE;
      end
      DONE: begin
        done_out = 1'b1;
        deg_out  = deg_q;
        err_out  = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      v_q        <= '0;
      proc_q     <= '0;
      beg_q      <= '0;
      ptr_q      <= '0;
      rem_q      <= '0;
      deg_q      <= '0;
      err_q      <= 1'b0;
      idx_pipe   <= '0;
      dat_pipe   <= '0;
      inflight_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        v_q    <= req_vertex;
        proc_q <= req_proc;
      end
      idx_pipe[1] <= rd_slot_t'{vld: idx_validin,   tag: state_q == IDX_HI};
      dat_pipe[1] <= rd_slot_t'{vld: data_validina, tag: rem_q == 32'd1};
      for (int i = 2; i <= RD_LAT; i++) begin
        idx_pipe[i] <= idx_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
      if (idx_ret_lo) beg_q <= rowidx_out;
      if (state_q == IDX_WAIT && idx_ret_hi) begin
        deg_q <= deg_w;
        err_q <= err_w;
        ptr_q <= beg_q;
        rem_q <= deg_w;
      end else if (data_validina) begin
        ptr_q <= ptr_q + 32'd1;
        rem_q <= rem_q - 32'd1;
      end
      inflight_q <= inflight_q + CW'(data_validina) - CW'(dat_pipe[RD_LAT].vld);
    end
  end

  csr_neighbor_fetcher_fifo #(
    .DATA_WIDTH (33),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (dat_pipe[RD_LAT].vld),
    .din    ({dat_pipe[RD_LAT].tag, data_outa}),
    .pop    (pop),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

endmodule
